pdu_run_ctrl: RTL and testbench

Run/step controller for the program debug unit (PDU) of the single-cycle CPU. It debounces the run switch and the step button, and sequences the CPU's clock enable through four modes: stop, single-step, free-run and breakpoint hold. It also keeps a retired-instruction count for the PDU display. It sits between the board I/O and the CPU's `cpu_en` input.

---
 rtl/pdu_pkg.sv | 16 +
 rtl/pdu_debounce.sv | 55 +++++
 rtl/pdu_run_ctrl.sv | 128 ++++++++++++
 tb/tb_pdu_run_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdu_pkg.sv
// Shared types for the program debug unit run/step controller.
package pdu_pkg;

  // Controller states; the encoding is visible on the mode output.
  typedef enum logic [1:0] {
    StStop  = 2'd0,
    StStep  = 2'd1,
    StRun   = 2'd2,
    StBreak = 2'd3
  } pdu_state_e;

  typedef logic [1:0] pdu_mode_t;

  localparam int unsigned InstrCntW = 32;

endpackage

// File: rtl/pdu_debounce.sv
// Debouncer for one raw board input: 2-FF synchronizer, hold counter and
// rising-edge detector on the debounced level.
module pdu_debounce #(
  parameter int unsigned DB_CNT = 1_000_000,
  parameter int unsigned DW     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam logic [DW-1:0] CntMax = DW'(DB_CNT - 1);

  logic [1:0]    sync_q;
  logic          db_q, db_d;
  logic          db_prev_q;
  logic [DW-1:0] cnt_q, cnt_d;

  // Hold counter: counts while the synchronized input disagrees with db.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CntMax) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  // Synchronizer, stable level, counter and previous level for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b00;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync_q    <= {sync_q[0], din};
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  // Level and one-cycle pulse in the cycle after db rises.
  always_comb begin
    dout = db_q;
    rise = db_q & ~db_prev_q;
  end

endmodule

// File: rtl/pdu_run_ctrl.sv
// Run/step controller: debounces run switch and step button and gates the
// CPU clock enable through stop, single-step, free-run and breakpoint hold.
module pdu_run_ctrl
  import pdu_pkg::*;
#(
  parameter int unsigned DB_CNT = 1_000_000,
  parameter int unsigned DW     = 20,
  parameter int unsigned AW     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_sw,
  input  logic                 step_btn,
  input  logic                 brk_en,
  input  logic [AW-1:0]        brk_addr,
  input  logic [AW-1:0]        pc,
  output logic                 cpu_en,
  output logic [1:0]           mode,
  output logic                 brk_hit,
  output logic [InstrCntW-1:0] instr_cnt
);

  logic run_db;
  logic run_rise_unused;
  logic step_db_unused;
  logic step_req;

  pdu_state_e           state_q, state_d;
  logic                 brk_hit_q;
  logic [InstrCntW-1:0] instr_cnt_q;
  logic                 hit;

  pdu_debounce #(
    .DB_CNT (DB_CNT),
    .DW     (DW)
  ) u_run_db (
    .clk  (clk),
    .rst  (rst),
    .din  (run_sw),
    .dout (run_db),
    .rise (run_rise_unused)
  );

  pdu_debounce #(
    .DB_CNT (DB_CNT),
    .DW     (DW)
  ) u_step_db (
    .clk  (clk),
    .rst  (rst),
    .din  (step_btn),
    .dout (step_db_unused),
    .rise (step_req)
  );

  // Breakpoint match is purely combinational so cpu_en drops in the same cycle.
  always_comb begin
    hit = brk_en && (pc == brk_addr);
  end

  // State register; brk_hit tracks the BREAK state one edge behind the match.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StStop;
      brk_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      brk_hit_q <= (state_d == StBreak);
    end
  end

  // Next-state logic; step requests outside STOP/BREAK are simply dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStop: begin
        if (run_db) begin
          state_d = StRun;
        end else if (step_req) begin
          state_d = StStep;
        end
      end
      StStep: begin
        state_d = StStop;
      end
      StRun: begin
        if (!run_db) begin
          state_d = StStop;
        end else if (hit) begin
          state_d = StBreak;
        end
      end
      StBreak: begin
        if (!run_db) begin
          state_d = StStop;
        end else if (step_req) begin
          // Stepping from BREAK skips the breakpoint check for that one instruction.
          state_d = StStep;
        end
      end
      default: state_d = StStop;
    endcase
  end

  // Outputs: enable for one cycle in STEP, every non-matching cycle in RUN.
  always_comb begin
    cpu_en = 1'b0;
    unique case (state_q)
      StStep:  cpu_en = 1'b1;
      StRun:   cpu_en = !hit;
      StStop,
      StBreak: cpu_en = 1'b0;
      default: cpu_en = 1'b0;
    endcase
    mode      = pdu_mode_t'(state_q);
    brk_hit   = brk_hit_q;
    instr_cnt = instr_cnt_q;
  end

  // Retired-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= '0;
    end else if (cpu_en) begin
      instr_cnt_q <= instr_cnt_q + InstrCntW'(1);
    end
  end

endmodule

// File: tb/tb_pdu_run_ctrl.sv
// Bench for pdu_run_ctrl with DB_CNT=4: directed stimulus pushes expected
// commits (pc, instr_cnt before increment); a negedge monitor pops and
// compares on every cpu_en cycle.
module tb_pdu_run_ctrl;

  localparam int unsigned DB_CNT = 4;
  localparam int unsigned DW     = 4;
  localparam int unsigned AW     = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cnt;
  } commit_t;

  logic          clk;
  logic          rst;
  logic          run_sw;
  logic          step_btn;
  logic          brk_en;
  logic [AW-1:0] brk_addr;
  logic [AW-1:0] pc;
  logic          cpu_en;
  logic [1:0]    mode;
  logic          brk_hit;
  logic [31:0]   instr_cnt;

  commit_t exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  pdu_run_ctrl #(
    .DB_CNT (DB_CNT),
    .DW     (DW),
    .AW     (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .brk_en    (brk_en),
    .brk_addr  (brk_addr),
    .pc        (pc),
    .cpu_en    (cpu_en),
    .mode      (mode),
    .brk_hit   (brk_hit),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU PC model: advances by one instruction per enabled cycle.
  always @(posedge clk) begin
    if (rst) pc <= '0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] c);
    commit_t e;
    e.pc  = p;
    e.cnt = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every enabled cycle must match the next expected commit.
  always @(negedge clk) begin
    if (cpu_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_commit: got pc %h cnt %h, expected no enable", pc, instr_cnt);
      end else begin
        commit_t e;
        e = exp_q.pop_front();
        check32("commit_pc", pc, e.pc);
        check32("commit_cnt", instr_cnt, e.cnt);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    run_sw   = 1'b0;
    step_btn = 1'b0;
    brk_en   = 1'b0;
    brk_addr = '0;
    repeat (3) tick();
    rst = 1'b0;

    // 1. Reset values, then a 10-cycle step press.
    check32("rst_mode", 32'(mode), 32'd0);
    check32("rst_cpu_en", 32'(cpu_en), 32'd0);
    check32("rst_brk_hit", 32'(brk_hit), 32'd0);
    check32("rst_instr_cnt", instr_cnt, 32'd0);
    push(32'h0, 32'd0);
    step_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 10) step_btn = 1'b0;
      if (i == 6) check32("step_not_yet", 32'(mode), 32'd0);
      if (i == 7) begin
        check32("step_mode", 32'(mode), 32'd1);
        check32("step_cpu_en", 32'(cpu_en), 32'd1);
      end
      if (i == 8) begin
        check32("step_done_cnt", instr_cnt, 32'd1);
        check32("step_done_mode", 32'(mode), 32'd0);
      end
    end
    repeat (10) tick();

    // 2. Three-cycle glitch on run_sw is rejected.
    run_sw = 1'b1;
    repeat (3) tick();
    run_sw = 1'b0;
    repeat (15) tick();
    check32("glitch_mode", 32'(mode), 32'd0);
    check32("glitch_cnt", instr_cnt, 32'd1);

    // 3. Free run from a clean reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check32("rerst_cnt", instr_cnt, 32'd0);
    run_sw = 1'b1;
    repeat (6) tick();
    check32("run_not_yet", 32'(mode), 32'd0);
    tick();
    check32("run_mode", 32'(mode), 32'd2);
    check32("run_cpu_en", 32'(cpu_en), 32'd1);
    for (int i = 0; i < 100; i++) push(32'(4 * i), 32'(i));
    repeat (100) tick();
    check32("run_cnt_100", instr_cnt, 32'd100);
    run_sw = 1'b0;
    for (int i = 100; i < 107; i++) push(32'(4 * i), 32'(i));
    repeat (6) tick();
    check32("stop_not_yet", 32'(mode), 32'd2);
    tick();
    check32("stop_mode", 32'(mode), 32'd0);
    check32("stop_cpu_en", 32'(cpu_en), 32'd0);
    check32("stop_cnt", instr_cnt, 32'd107);

    // 4. Breakpoint at 0x10.
    rst      = 1'b1;
    brk_en   = 1'b1;
    brk_addr = 32'h0000_0010;
    tick();
    rst    = 1'b0;
    run_sw = 1'b1;
    push(32'h0, 32'd0);
    push(32'h4, 32'd1);
    push(32'h8, 32'd2);
    push(32'hC, 32'd3);
    repeat (11) tick();
    check32("brk_pc", pc, 32'h10);
    check32("brk_cpu_en", 32'(cpu_en), 32'd0);
    check32("brk_hit_lag", 32'(brk_hit), 32'd0);
    tick();
    check32("brk_mode", 32'(mode), 32'd3);
    check32("brk_hit", 32'(brk_hit), 32'd1);
    check32("brk_cnt", instr_cnt, 32'd4);

    // 5. Step past the breakpoint, then run resumes.
    step_btn = 1'b1;
    push(32'h10, 32'd4);
    push(32'h14, 32'd5);
    push(32'h18, 32'd6);
    push(32'h1C, 32'd7);
    repeat (6) tick();
    check32("bstep_hold", 32'(mode), 32'd3);
    tick();
    check32("bstep_mode", 32'(mode), 32'd1);
    check32("bstep_cpu_en", 32'(cpu_en), 32'd1);
    tick();
    step_btn = 1'b0;
    check32("bstep_stop", 32'(mode), 32'd0);
    check32("bstep_brk_hit", 32'(brk_hit), 32'd0);
    check32("bstep_pc", pc, 32'h14);
    tick();
    check32("resume_mode", 32'(mode), 32'd2);
    check32("resume_cpu_en", 32'(cpu_en), 32'd1);
    repeat (3) tick();
    check32("resume_pc", pc, 32'h20);
    check32("resume_no_hit", 32'(brk_hit), 32'd0);
    check32("resume_cnt", instr_cnt, 32'd8);

    // 6. Counter wrap, then reset during RUN.
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_cnt_q;
    push(32'h20, 32'hFFFF_FFFF);
    tick();
    check32("wrap_cnt", instr_cnt, 32'd0);
    push(32'h24, 32'd0);
    rst    = 1'b1;
    run_sw = 1'b0;
    brk_en = 1'b0;
    tick();
    check32("rrst_mode", 32'(mode), 32'd0);
    check32("rrst_cpu_en", 32'(cpu_en), 32'd0);
    check32("rrst_cnt", instr_cnt, 32'd0);
    rst = 1'b0;
    repeat (10) tick();
    check32("rrst_idle_mode", 32'(mode), 32'd0);
    check32("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
